// File: rtl/serial_pattern_tx.sv
// ---------------------------------------------------------------------------
// serial_pattern_tx
//
// Loads a parallel word and shifts it out LSB first, one bit per clock, on a
// single registered serial line. An internal overlapping "0110" Moore tracker
// watches the emitted stream and reports a per-bit match flag plus a
// saturating count of matches in the current (or most recent) word.
//
// Parameters
//   WIDTH  bits per transmitted word (>= 4)
//   CNT_W  width of match_count; the count saturates at all-ones
//
// Ports
//   clk          in   clock, all state changes on the rising edge
//   reset        in   synchronous, active-high; overrides every other input
//   start        in   transmit request, sampled only while idle
//   data_in      in   word to send, captured on the edge that accepts start
//   x            out  serial data, idles at 1
//   valid        out  high while x carries a data bit
//   busy         out  high from accept until the block is idle again
//   done         out  one-cycle pulse after the last bit was consumed
//   match        out  high while the tracker sits in S4 ("0110" completed)
//   match_count  out  overlapping "0110" occurrences in the current word
//
// Every output comes straight from a flop; there is no combinational path
// from any input to any output.
// ---------------------------------------------------------------------------
module serial_pattern_tx #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             x,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic             match,
    output logic [CNT_W-1:0] match_count
);

    localparam int              BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0]   LAST_BIT = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        TRK_S0,
        TRK_S1,
        TRK_S2,
        TRK_S3,
        TRK_S4
    } trk_t;

    state_t             state_q, state_d;
    trk_t               trk_q,   trk_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [BW-1:0]      bitcnt_q, bitcnt_d;
    logic               x_q,     x_d;
    logic               valid_q, valid_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;
    logic               match_q, match_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        trk_d    = trk_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        x_d      = x_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;

        // Tracker consumes the bit currently on the line. It only moves on
        // edges where valid is high, so it freezes in IDLE and DONE and the
        // final count of a word stays readable until the next accept.
        if (valid_q) begin
            case (trk_q)
                TRK_S0:  trk_d = x_q ? TRK_S0 : TRK_S1;
                TRK_S1:  trk_d = x_q ? TRK_S2 : TRK_S1;
                TRK_S2:  trk_d = x_q ? TRK_S3 : TRK_S1;
                TRK_S3:  trk_d = x_q ? TRK_S0 : TRK_S4;
                TRK_S4:  trk_d = x_q ? TRK_S2 : TRK_S1;
                default: trk_d = TRK_S0;
            endcase
            if ((trk_d == TRK_S4) && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                x_d     = 1'b1;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (start) begin
                    // Accept: first data bit goes on the line immediately,
                    // and the tracker restarts for the new word.
                    state_d  = ST_SHIFT;
                    shreg_d  = data_in;
                    x_d      = data_in[0];
                    valid_d  = 1'b1;
                    busy_d   = 1'b1;
                    bitcnt_d = '0;
                    trk_d    = TRK_S0;
                    cnt_d    = '0;
                end
            end

            ST_SHIFT: begin
                if (bitcnt_q == LAST_BIT) begin
                    // Last bit has had its cycle on the line
                    state_d = ST_DONE;
                    x_d     = 1'b1;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    shreg_d  = shreg_q >> 1;
                    x_d      = shreg_d[0];
                    bitcnt_d = bitcnt_q + BW'(1);
                end
            end

            ST_DONE: begin
                // start is deliberately ignored here
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                x_d     = 1'b1;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        match_d = (trk_d == TRK_S4);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            trk_q    <= TRK_S0;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            x_q      <= 1'b1;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            match_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            trk_q    <= trk_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            x_q      <= x_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            match_q  <= match_d;
            cnt_q    <= cnt_d;
        end
    end

    assign x           = x_q;
    assign valid       = valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign match       = match_q;
    assign match_count = cnt_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// ---------------------------------------------------------------------------
// tb_serial_pattern_tx
//
// Self-checking bench for serial_pattern_tx (WIDTH=16, CNT_W=5). Expected
// values come from a pattern-window model: a "0110" completes at bit k when
// bits k-3..k of the word read 0,1,1,0, and the count is the number of such
// windows seen so far, saturated at 31.
// ---------------------------------------------------------------------------
module tb_serial_pattern_tx;

    localparam int W  = 16;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  data_in;
    logic          x;
    logic          valid;
    logic          busy;
    logic          done;
    logic          match;
    logic [CW-1:0] match_count;

    int checks   = 0;
    int failures = 0;

    serial_pattern_tx #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .data_in     (data_in),
        .x           (x),
        .valid       (valid),
        .busy        (busy),
        .done        (done),
        .match       (match),
        .match_count (match_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit mbit(input logic [W-1:0] d, input int k);
        if (k < 3) return 1'b0;
        return (d[k -: 4] == 4'b0110);
    endfunction

    // matches completed in bits 0..n-1
    function automatic int cnt_upto(input logic [W-1:0] d, input int n);
        int c = 0;
        for (int k = 0; k < n; k++) c += int'(mbit(d, k));
        return (c > (1 << CW) - 1) ? (1 << CW) - 1 : c;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Sends one word from IDLE and checks every cycle through to IDLE.
    // pulse_k >= 0 raises start (with different data) before edge T+pulse_k+1;
    // pulse_done raises start during the DONE cycle.
    task automatic run_word(input logic [W-1:0] d, input string tag,
                            input int pulse_k, input bit pulse_done);
        logic [W-1:0] dd;
        dd = d;
        start = 1'b1; data_in = dd;
        step;
        start = 1'b0; data_in = W'($urandom);
        for (int k = 0; k < W; k++) begin
            checks++;
            if (x !== dd[k] || valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL %s bit%0d: x=%b valid=%b busy=%b done=%b, want x=%b valid=1 busy=1 done=0",
                         tag, k, x, valid, busy, done, dd[k]);
            end
            checks++;
            if (match !== ((k > 0) ? mbit(dd, k - 1) : 1'b0)) begin
                failures++;
                $display("FAIL %s match@bit%0d: got %b want %b", tag, k, match,
                         (k > 0) ? mbit(dd, k - 1) : 1'b0);
            end
            checks++;
            if (match_count !== CW'(cnt_upto(dd, k))) begin
                failures++;
                $display("FAIL %s count@bit%0d: got %0d want %0d", tag, k, match_count, cnt_upto(dd, k));
            end
            if (k == pulse_k) begin
                start = 1'b1; data_in = ~dd;
            end else begin
                start = 1'b0;
            end
            step;
        end
        start = 1'b0;
        // cycle after edge T+W: DONE
        checks++;
        if (x !== 1'b1 || valid !== 1'b0 || busy !== 1'b1 || done !== 1'b1) begin
            failures++;
            $display("FAIL %s done_cycle: x=%b valid=%b busy=%b done=%b, want x=1 valid=0 busy=1 done=1",
                     tag, x, valid, busy, done);
        end
        checks++;
        if (match !== mbit(dd, W - 1) || match_count !== CW'(cnt_upto(dd, W))) begin
            failures++;
            $display("FAIL %s final: match=%b count=%0d, want match=%b count=%0d",
                     tag, match, match_count, mbit(dd, W - 1), cnt_upto(dd, W));
        end
        if (pulse_done) begin
            start = 1'b1; data_in = ~dd;
        end
        step;
        start = 1'b0;
        // back in IDLE
        checks++;
        if (x !== 1'b1 || valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            match_count !== CW'(cnt_upto(dd, W))) begin
            failures++;
            $display("FAIL %s idle: x=%b valid=%b busy=%b done=%b count=%0d, want 1 0 0 0 %0d",
                     tag, x, valid, busy, done, match_count, cnt_upto(dd, W));
        end
        if (pulse_done) begin
            step;
            checks++;
            if (busy !== 1'b0 || valid !== 1'b0) begin
                failures++;
                $display("FAIL %s start_in_done_accepted: busy=%b valid=%b want 0 0", tag, busy, valid);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        reset = 1'b1; start = 1'b1; data_in = 16'h6DB6;
        for (int i = 0; i < 2; i++) begin
            step;
            checks++;
            if (x !== 1'b1 || valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
                match !== 1'b0 || match_count !== '0) begin
                failures++;
                $display("FAIL reset cyc%0d: x=%b valid=%b busy=%b done=%b match=%b count=%0d, want 1 0 0 0 0 0",
                         i, x, valid, busy, done, match, match_count);
            end
        end
        reset = 1'b0; start = 1'b0;
        step;
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || x !== 1'b1) begin
            failures++;
            $display("FAIL reset_start_ignored: busy=%b valid=%b x=%b want 0 0 1", busy, valid, x);
        end
    endtask

    task automatic test_patterns;
        run_word(16'b0110110110101100, "mixed",   -1, 1'b0);
        run_word(16'h6DB6,             "overlap", -1, 1'b0);
        run_word(16'h0000,             "zeros",   -1, 1'b0);
        run_word(16'hFFFF,             "ones",    -1, 1'b0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 8; i++) begin
            run_word(W'($urandom), "random", -1, 1'b0);
            repeat ($urandom_range(0, 3)) step;
        end
    endtask

    task automatic test_ignore_start;
        run_word(16'h36C9, "ignore_shift", 5, 1'b0);
        run_word(16'h6DB6, "ignore_last", W - 1, 1'b1);
    endtask

    task automatic test_hold;
        run_word(16'h6DB6, "hold_w1", -1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step;
            checks++;
            if (match_count !== CW'(5) || match !== 1'b1 || busy !== 1'b0) begin
                failures++;
                $display("FAIL hold idle%0d: count=%0d match=%b busy=%b want 5 1 0", i, match_count, match, busy);
            end
        end
        run_word(16'h0F0F, "hold_w2", -1, 1'b0);
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] b;
        int p;
        bit got_idle;
        b = W'($urandom);
        start = 1'b1; data_in = b;
        for (int c = 0; c < 40; c++) begin
            step;
            p = c % (W + 2);
            checks++;
            if (valid !== (p < W) || x !== ((p < W) ? b[p] : 1'b1) ||
                done !== (p == W) || busy !== (p <= W)) begin
                failures++;
                $display("FAIL b2b c%0d: valid=%b x=%b done=%b busy=%b, want %b %b %b %b",
                         c, valid, x, done, busy, (p < W), (p < W) ? b[p] : 1'b1, (p == W), (p <= W));
            end
            checks++;
            if (match_count !== CW'(cnt_upto(b, (p < W) ? p : W)) ||
                match !== ((p == 0) ? 1'b0 : mbit(b, (p <= W) ? p - 1 : W - 1))) begin
                failures++;
                $display("FAIL b2b_track c%0d: count=%0d match=%b, want %0d %b", c, match_count, match,
                         cnt_upto(b, (p < W) ? p : W), (p == 0) ? 1'b0 : mbit(b, (p <= W) ? p - 1 : W - 1));
            end
        end
        start = 1'b0;
        got_idle = 1'b0;
        for (int i = 0; i < 40 && !got_idle; i++) begin
            step;
            if (busy === 1'b0) got_idle = 1'b1;
        end
        checks++;
        if (!got_idle) begin
            failures++;
            $display("FAIL b2b_drain: busy=%b still set after 40 cycles, want 0", busy);
        end
    endtask

    task automatic test_midword_reset;
        start = 1'b1; data_in = 16'h6DB6;
        step;
        start = 1'b0;
        repeat (7) step;
        checks++;
        if (x !== 1'b1 || valid !== 1'b1) begin  // bit 7 of 6DB6 is 1
            failures++;
            $display("FAIL midreset_pre: x=%b valid=%b want 1 1", x, valid);
        end
        reset = 1'b1; start = 1'b1;
        step;
        checks++;
        if (x !== 1'b1 || valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            match !== 1'b0 || match_count !== '0) begin
            failures++;
            $display("FAIL midreset: x=%b valid=%b busy=%b done=%b match=%b count=%0d, want 1 0 0 0 0 0",
                     x, valid, busy, done, match, match_count);
        end
        reset = 1'b0; start = 1'b0;
        repeat (2) step;
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_resumed: busy=%b valid=%b want 0 0", busy, valid);
        end
        run_word(16'h6DB6, "after_reset", -1, 1'b0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; data_in = '0;
        test_reset;
        test_patterns;
        test_random;
        test_ignore_start;
        test_hold;
        test_back_to_back;
        test_midword_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
